bnn_frame_feeder: RTL and testbench
===================================

// Module: bnn_frame_feeder
// PURPOSE
//  Producer side of the BNN conv input interface: buffers NUM_FRAMES binarized feature rows
//  (FEAT_W bits each) from the VAD front end, then streams KERNEL_W-bit sliding windows to the
//  binary conv stage one per handshake.
//  Default 6 rows x 6 windows = 36 windows per block, matching the conv's 36-step schedule.
//  Sits between the feature binarizer and the conv.
// PARAMETERS
//  FEAT_W      20  bits per feature row
//  NUM_FRAMES  6   rows buffered per block
//  KERNEL_W    5   window width = conv data_in width
//  STRIDE      3   window step along a row; NPOS = (FEAT_W-KERNEL_W)/STRIDE+1 (6 by default)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous reset, active high
//  in_data    in   FEAT_W    binarized feature row (1 = +1, 0 = -1)
//  in_valid   in   1         in_data valid
//  in_ready   out  1         feeder accepts a row this cycle
//  win_data   out  KERNEL_W  window to conv; win_data[KERNEL_W-1] = highest row bit of window
//  win_valid  out  1         win_data valid
//  win_ready  in   1         conv consumes window this cycle
//  win_last   out  1         high with the final window (row NUM_FRAMES-1, position NPOS-1)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge) gives:
//      state=FILL; row_cnt=0; pos_cnt=0.
//      win_valid=0, win_data=0, win_last=0.
//      in_ready=0 for the whole cycle rst is high.
//    Row buffer contents are don't-care after reset.
//  - Reset mid-FILL or mid-STREAM abandons the block. No partial window or win_last is emitted
//    afterwards.
//  - FILL state:
//      in_ready=1, win_valid=0.
//      Each in_valid&&in_ready edge writes in_data to buf[row_cnt] and increments row_cnt.
//      On the edge that accepts row NUM_FRAMES-1:
//        state->STREAM, row_cnt->0, pos_cnt->0.
//        win_data <= that row's window? No: win_data <= buf[0] window 0 (bits KERNEL_W-1:0).
//        win_valid<=1.
//      Latency: first window is valid the cycle after the last row is accepted.
//  - STREAM state:
//      in_ready=0; incoming rows are not accepted.
//      Window (r,p) = buf[r][p*STRIDE+KERNEL_W-1 : p*STRIDE].
//      While win_valid && !win_ready: win_data, win_valid and win_last hold stable.
//      On a handshake, the next window loads at that edge:
//        pos_cnt++; at NPOS-1 pos_cnt wraps to 0 and row_cnt++.
//      Order: row 0 pos 0..NPOS-1, then row 1, and so on. win_valid stays high back-to-back
//      (one window per cycle when win_ready=1).
//      win_last=1 exactly while window (NUM_FRAMES-1, NPOS-1) is presented.
//      On its handshake: win_valid<=0, win_last<=0, row_cnt<=0, state->FILL.
//      in_ready goes high the next cycle (no bubble beyond one cycle).
//  - Counters: row_cnt width clog2(NUM_FRAMES), pos_cnt width clog2(NPOS). No other wrap paths.
//  - Windows are bit slices only; no arithmetic. Upper bits beyond the last full window are
//    ignored when (FEAT_W-KERNEL_W)%STRIDE != 0.
//  - in_valid while in_ready=0 has no effect; the source must hold the row.
// TESTING
//  1 Reset: rst=1 two cycles -> win_valid=0, win_data=0, win_last=0, in_ready=0. After rst=0,
//    in_ready=1.
//  2 Basic block: rows k=0..5 in_data=20'hA5A5A ^ k with win_ready=1 ->
//      first win_valid the cycle after row 5 accepted;
//      36 consecutive windows equal to in_data[k][3p+4:3p] in row-major order;
//      win_last only on the 36th;
//      in_ready=1 the cycle after.
//  3 Backpressure: random win_ready (~50%) during STREAM -> win_data/win_last stable while
//    stalled; the same 36-window sequence as scenario 2, no drops or duplicates.
//  4 Source gaps / ignore: in_valid toggled with idle cycles in FILL -> only valid rows stored.
//    in_valid=1 during STREAM -> no row accepted, output unchanged.
//  5 Back-to-back blocks: second block with row data 20'h0F0F0 queued during STREAM of the
//    first -> second accepted only after win_last handshake; its windows are correct (no stale
//    data from block 1).
//  6 Reset mid-stream: assert rst after window 17 handshake -> win_valid=0 next edge. A fresh
//    6-row block then yields a full 36 windows starting at row 0 pos 0.

Source files
------------

// File: rtl/bnn_frame_feeder.sv
// Buffers NUM_FRAMES binarized feature rows, then streams KERNEL_W-bit sliding windows
// (row-major, STRIDE apart) to the binary conv stage over a valid/ready handshake.
module bnn_frame_feeder #(
    parameter int FEAT_W     = 20,
    parameter int NUM_FRAMES = 6,
    parameter int KERNEL_W   = 5,
    parameter int STRIDE     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [FEAT_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [KERNEL_W-1:0] win_data,
    output logic                win_valid,
    input  logic                win_ready,
    output logic                win_last,
    output logic                dbg_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds data stable while valid is high and ready is low.
    localparam int NPOS = (FEAT_W - KERNEL_W) / STRIDE + 1;
    localparam int RW   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int PW   = (NPOS > 1) ? $clog2(NPOS) : 1;
    localparam bit SINGLE_WINDOW = (NUM_FRAMES == 1) && (NPOS == 1);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                state_q;
    logic [RW-1:0]         row_q, row_d;
    logic [PW-1:0]         pos_q, pos_d;
    logic [KERNEL_W-1:0]   win_data_q, next_win;
    logic                  win_valid_q, win_last_q, next_last;
    logic [FEAT_W-1:0]     buf_q [NUM_FRAMES];
    logic [FEAT_W-1:0]     first_src;
    logic                  fill_fire, last_row, last_pos;

    function automatic logic [KERNEL_W-1:0] win_slice(input logic [FEAT_W-1:0] row,
                                                      input logic [PW-1:0]     p);
        logic [FEAT_W-1:0] sh;
        sh = row >> (int'(p) * STRIDE);
        return sh[KERNEL_W-1:0];
    endfunction

    assign in_ready    = (state_q == FILL) && !rst;
    assign fill_fire   = in_valid && in_ready;
    assign win_data    = win_data_q;
    assign win_valid   = win_valid_q;
    assign win_last    = win_last_q;
    assign dbg_state_o = state_q;

    assign last_row = (row_q == RW'(NUM_FRAMES - 1));
    assign last_pos = (pos_q == PW'(NPOS - 1));
    // With a single-row block the first window comes straight from the row being accepted.
    assign first_src = (row_q == '0) ? in_data : buf_q[0];

    always_comb begin
        pos_d = pos_q + PW'(1);
        row_d = row_q;
        if (last_pos) begin
            pos_d = '0;
            row_d = last_row ? '0 : row_q + RW'(1);
        end
        next_win  = win_slice(buf_q[row_d], pos_d);
        next_last = (row_d == RW'(NUM_FRAMES - 1)) && (pos_d == PW'(NPOS - 1));
    end

    // Row storage carries no reset; its contents only matter once a block is complete.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            buf_q[row_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            row_q       <= '0;
            pos_q       <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fill_fire) begin
                        if (last_row) begin
                            state_q     <= STREAM;
                            row_q       <= '0;
                            pos_q       <= '0;
                            win_data_q  <= win_slice(first_src, '0);
                            win_valid_q <= 1'b1;
                            win_last_q  <= SINGLE_WINDOW;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (win_ready) begin
                        if (win_last_q) begin
                            state_q     <= FILL;
                            row_q       <= '0;
                            pos_q       <= '0;
                            win_valid_q <= 1'b0;
                            win_last_q  <= 1'b0;
                        end else begin
                            row_q      <= row_d;
                            pos_q      <= pos_d;
                            win_data_q <= next_win;
                            win_last_q <= next_last;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_frame_feeder.sv
// Randomized scoreboard bench for bnn_frame_feeder: accepted rows feed a window model whose
// expected windows are queued and popped by a negedge monitor on each window handshake.
module tb_bnn_frame_feeder;
    localparam int FEAT_W = 20;
    localparam int NF     = 6;
    localparam int KW     = 5;
    localparam int ST     = 3;
    localparam int NPOS   = (FEAT_W - KW) / ST + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [FEAT_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [KW-1:0]     win_data;
    logic              win_valid;
    logic              win_ready;
    logic              win_last;
    logic              dbg_state;

    bnn_frame_feeder #(.FEAT_W(FEAT_W), .NUM_FRAMES(NF), .KERNEL_W(KW), .STRIDE(ST)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
        .win_last(win_last), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [KW:0]       exp_q[$];
    logic [FEAT_W-1:0] rows_q[$];
    bit  streaming  = 1'b0;
    bit  prev_rst   = 1'b0;
    bit  prev_stall = 1'b0;
    logic [KW-1:0] prev_data;
    logic          prev_last;
    int  pop_cnt    = 0;
    bit  ready_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor and reference model: windows of a block are (row >> STRIDE*p) mod 2^KW.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_rst", 32'(in_ready), 32'd0);
            if (prev_rst) begin
                check("win_valid_rst", 32'(win_valid), 32'd0);
                check("win_data_rst", 32'(win_data), 32'd0);
                check("win_last_rst", 32'(win_last), 32'd0);
            end
            exp_q.delete();
            rows_q.delete();
            streaming  = 1'b0;
            prev_stall = 1'b0;
            pop_cnt    = 0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!streaming));
            check("win_valid", 32'(win_valid), 32'(streaming));
            if (prev_stall) begin
                check("stall_data", 32'(win_data), 32'(prev_data));
                check("stall_last", 32'(win_last), 32'(prev_last));
            end
            if (win_valid) begin
                if (exp_q.size() == 0) begin
                    check("win_extra", 32'(win_valid), 32'd0);
                end else begin
                    logic [KW:0] e;
                    e = exp_q[0];
                    check("win_data", 32'(win_data), 32'(e[KW-1:0]));
                    check("win_last", 32'(win_last), 32'(e[KW]));
                    if (win_ready) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                        if (e[KW]) streaming = 1'b0;
                    end
                end
            end
            prev_stall = win_valid && !win_ready;
            prev_data  = win_data;
            prev_last  = win_last;
            if (in_valid && in_ready) begin
                rows_q.push_back(in_data);
                if (rows_q.size() == NF) begin
                    for (int r = 0; r < NF; r++) begin
                        for (int p = 0; p < NPOS; p++) begin
                            logic [FEAT_W-1:0] sh;
                            sh = rows_q[r] >> (p * ST);
                            exp_q.push_back({(r == NF - 1) && (p == NPOS - 1), sh[KW-1:0]});
                        end
                    end
                    rows_q.delete();
                    streaming = 1'b1;
                    pop_cnt   = 0;
                end
            end
        end
        prev_rst = rst;
    end

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            win_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_row(input logic [FEAT_W-1:0] d, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = FEAT_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (in_ready || n >= 500) break;
            n++;
        end
        if (n >= 500) check("row_accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int kind, input int gap_max);
        logic [FEAT_W-1:0] d;
        for (int k = 0; k < NF; k++) begin
            if (kind == 0)      d = 20'hA5A5A ^ FEAT_W'(k);
            else if (kind == 1) d = 20'h0F0F0 ^ FEAT_W'(k);
            else                d = FEAT_W'($urandom);
            send_row(d, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((streaming || rows_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout", 32'(n >= 2000), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        do_reset(2);

        send_block(0, 0);
        wait_idle();

        ready_rand = 1'b1;
        send_block(0, 0);
        wait_idle();

        send_block(2, 3);
        wait_idle();

        send_block(2, 1);
        send_block(1, 0);
        wait_idle();

        ready_rand = 1'b0;
        send_block(2, 0);
        n = 0;
        while (pop_cnt < 18 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_stream_timeout", 32'(n >= 500), 32'd0);
        @(posedge clk);
        #1;
        do_reset(2);
        send_block(0, 0);
        wait_idle();

        ready_rand = 1'b1;
        for (int b = 0; b < 4; b++) begin
            send_block(2, 2);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
